fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller for the team's synchronous FIFO: on a start command it drains exactly `i_len` words from the FIFO read port and presents them downstream on a valid/ready stream, marking the final word with `o_last`. It sits between the FIFO (`i_rden`/`o_rddata`/`o_empty`/`o_alm_empty`) and a consumer that may stall. It hides the FIFO's one-cycle read latency behind a 2-entry skid buffer.

## Interface
- `DATA_WIDTH`, 128, word width; must match the FIFO.
- `LEN_WIDTH`, 8, width of the burst length.
- `TIMEOUT`, 256, stall cycles before a burst aborts; used only with `FIFO_RD_TIMEOUT_EN`.

- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  burst request; sampled only in IDLE.
- `i_len`  in  LEN_WIDTH  words to read; latched with `i_start`.
- `o_busy`  out  1  high in RUN and FLUSH.
- `o_done`  out  1  one-cycle pulse when a burst completes or aborts.
- `o_err`  out  1  one-cycle pulse coincident with `o_done` on timeout abort.
- `o_rden`  out  1  FIFO read enable; drives the FIFO `i_rden`.
- `i_rddata`  in  DATA_WIDTH  FIFO read data; valid the cycle after `o_rden`.
- `i_empty`  in  1  FIFO empty flag.
- `i_alm_empty`  in  1  FIFO almost-empty flag.
- `o_valid`  out  1  downstream data valid.
- `i_ready`  in  1  downstream ready.
- `o_data`  out  DATA_WIDTH  downstream data.
- `o_last`  out  1  qualifies the final word of a burst.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE: if `i_start` is high and `i_len != 0`, latch `i_len` into the issue and deliver counters and go to RUN.
  - If `i_start` is high and `i_len == 0`, pulse `o_done` next cycle and stay in IDLE.
- `i_start` is ignored outside IDLE.
- RUN: `o_rden` is high when all of the following hold:
  - issue count remaining > 0;
  - `i_empty` is low;
  - buffered + in-flight − (pop this cycle) < 2;
  - `i_alm_empty` is low, or in-flight == 0.
  - The last condition absorbs the FIFO flag lag: near empty, at most one read is outstanding.
- `o_rden` is combinational from registered state and the FIFO flags.
- Words returned by the FIFO are captured into the 2-entry skid buffer in order. `o_data`/`o_valid` come from the buffer head.
- A pop occurs when `o_valid && i_ready`. The deliver counter decrements on each pop.
- `o_last` is high on the head word when the deliver count == 1.
- When the issue count reaches 0, go to FLUSH.
- FLUSH: when the last word pops, pulse `o_done` next cycle and go to IDLE.
- Arithmetic: counters are LEN_WIDTH bits; `i_len` up to 2^LEN_WIDTH−1. No wrap is possible.
- Reset mid-burst: FSM to IDLE, buffer cleared, in-flight data dropped. Unread FIFO words stay in the FIFO.

## Timing
- Reset values: `o_busy`, `o_done`, `o_err`, `o_rden`, `o_valid`, `o_last` = 0; `o_data` = 0.
- `i_start` sampled at edge 0 → `o_rden` may assert in cycle 1 → `i_rddata` valid in cycle 2 → `o_valid` high in cycle 3.
- Throughput: 1 word/cycle while `i_alm_empty` = 0 and `i_ready` = 1. With `i_alm_empty` = 1, at most 1 word per 2 cycles.
- `o_valid`, `o_data` and `o_last` are held stable while `i_ready` is low.
- The buffer never overflows: the issue rule above guarantees ≤ 2 words held or in flight.

## Configuration
- `FIFO_RD_TIMEOUT_EN` defined:
  - A stall counter counts consecutive RUN cycles with issue count > 0 and `i_empty` high. It clears on any `o_rden`.
  - At TIMEOUT, issuing stops and the FSM goes to FLUSH.
  - Already-captured words are delivered; `o_last` is not asserted on them.
  - `o_done` and `o_err` pulse together after the buffer drains.
- Undefined: no stall counter. RUN waits indefinitely on an empty FIFO, and `o_err` is tied to 0.

## Test plan
- FIFO preloaded with 0x1..0x8, `i_len`=4, `i_ready`=1 → `o_data` 0x1,0x2,0x3,0x4 on consecutive cycles, first in cycle 3; `o_last` with 0x4; `o_done` one cycle later; 4 words remain in the FIFO.
- `i_len`=6, `i_ready` toggling 1/0 every cycle → all 6 words delivered in order, no duplicates or drops; `o_rden` count = 6.
- FIFO holds 2 words with `i_alm_empty`=1, `i_len`=2 → `o_rden` never high on two consecutive cycles; 2 words delivered; `o_last` on the 2nd.
- `i_len`=0 with `i_start` → `o_done` pulse next cycle, `o_busy` stays 0, no `o_rden`.
- With `FIFO_RD_TIMEOUT_EN`, TIMEOUT=16: 3 words in FIFO, `i_len`=5 → 3 words delivered without `o_last`; `o_done` and `o_err` high together; back in IDLE.
- `rstn` low in the middle of a 6-word burst → all outputs 0 immediately; a new `i_start` after release runs normally.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// rtl/fifo_rd_ctrl_if.sv - downstream valid/ready word stream leaving the FIFO read controller
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_last;

    modport master (
        output o_valid,
        output o_data,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid,
        input  o_data,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - drains a burst of i_len words from the FIFO into a stream; optional stall abort under FIFO_RD_TIMEOUT_EN
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 8
`ifdef FIFO_RD_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 256
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_rden,
    input  logic [DATA_WIDTH-1:0] i_rddata,
    input  logic                  i_empty,
    input  logic                  i_alm_empty,
    fifo_rd_ctrl_if.master        dn
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic [LEN_WIDTH-1:0]  deliver_cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic [1:0]            buf_cnt;
    logic                  done_q;
    logic                  abort_q;

    logic                  head_valid;
    logic                  pop;
    logic [1:0]            occ_after_pop;
    logic                  start_ok;
    logic                  start_zero;
    logic                  burst_end;
    logic                  stall_hit;

    assign head_valid    = (buf_cnt != 2'd0);
    assign pop           = head_valid && dn.i_ready;
    // words held plus the word still coming back from the FIFO, after this cycle's pop
    assign occ_after_pop = buf_cnt + {1'b0, inflight} - {1'b0, pop};
    assign start_ok      = (state == S_IDLE) && i_start && (i_len != '0);
    assign start_zero    = (state == S_IDLE) && i_start && (i_len == '0);
    // an aborted burst ends once the buffer is empty; a normal one on the final pop
    assign burst_end     = abort_q ? (occ_after_pop == 2'd0)
                                   : (pop && (deliver_cnt == LEN_WIDTH'(1)));

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt;
    logic               stalling;
    logic               err_q;

    assign stalling  = (state == S_RUN) && (issue_cnt != '0) && i_empty;
    assign stall_hit = stalling && (stall_cnt == STALL_W'(TIMEOUT - 1));
    assign o_err     = err_q;

    // count consecutive cycles stuck on an empty FIFO; any read restarts the count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (o_rden || (state != S_RUN)) begin
                stall_cnt <= '0;
            end else if (stalling) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            err_q <= (state == S_FLUSH) && burst_end && abort_q;
        end
    end
`else
    assign stall_hit = 1'b0;
    assign o_err     = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stall_hit) begin
                    state_nxt = S_FLUSH;
                end else if (o_rden && (issue_cnt == LEN_WIDTH'(1))) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (burst_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO read issue and busy flag; near empty only one read may be outstanding
    always_comb begin
        o_busy = (state != S_IDLE);
        o_rden = (state == S_RUN) && (issue_cnt != '0) && !i_empty &&
                 (occ_after_pop < 2'd2) && (!i_alm_empty || !inflight);
    end

    // burst counters, read-latency tracking, skid buffer and completion pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            inflight    <= 1'b0;
            skid0       <= '0;
            skid1       <= '0;
            buf_cnt     <= 2'd0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                issue_cnt   <= i_len;
                deliver_cnt <= i_len;
                abort_q     <= 1'b0;
            end else begin
                if (o_rden) issue_cnt   <= issue_cnt - LEN_WIDTH'(1);
                if (pop)    deliver_cnt <= deliver_cnt - LEN_WIDTH'(1);
                if (stall_hit) abort_q  <= 1'b1;
            end
            inflight <= o_rden;
            case ({inflight, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) skid0 <= i_rddata;
                    else                 skid1 <= i_rddata;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    skid0   <= skid1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        skid0 <= i_rddata;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= i_rddata;
                    end
                end
                default: ;
            endcase
            done_q <= start_zero || ((state == S_FLUSH) && burst_end);
        end
    end

    assign o_done     = done_q;
    assign dn.o_valid = head_valid;
    assign dn.o_data  = skid0;
    assign dn.o_last  = head_valid && (deliver_cnt == LEN_WIDTH'(1)) && !abort_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - randomized self-checking bench for fifo_rd_ctrl against a queue-based FIFO/burst model
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;
    localparam int DW = 128;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_len = '0;
    logic          o_busy, o_done, o_err, o_rden;
    logic [DW-1:0] i_rddata = '0;
    logic          i_empty = 1'b1;
    logic          i_alm_empty = 1'b1;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) dn ();

    fifo_rd_ctrl #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
`ifdef FIFO_RD_TIMEOUT_EN
        ,
        .TIMEOUT   (16)
`endif
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_start    (i_start),
        .i_len      (i_len),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_rden     (o_rden),
        .i_rddata   (i_rddata),
        .i_empty    (i_empty),
        .i_alm_empty(i_alm_empty),
        .dn         (dn)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: a queue, read data registered one cycle after the read request
    logic [DW-1:0] fq[$];
    int            alm_thr = 1;
    logic          rd_req = 1'b0;

    always @(posedge clk) begin
        int sz;
        if (rd_req && fq.size() > 0) i_rddata <= fq.pop_front();
        sz = fq.size();
        i_empty     <= (sz == 0);
        i_alm_empty <= (sz <= alm_thr);
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // monitor, sampled mid-cycle
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            got_c[$];
    int n_rden, n_consec, n_bad_rd, n_unstable, n_done, n_err, n_err_done, n_busy;
    int start_cyc, done_cyc;
    logic          prev_rden = 1'b0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;

    always @(negedge clk) begin
        rd_req = o_rden;
        if (!rstn) begin
            hold_v = 1'b0;
        end else begin
            if (o_rden) begin
                n_rden++;
                if (prev_rden) n_consec++;
                if (i_empty) n_bad_rd++;
            end
            if (hold_v && !(dn.o_valid && dn.o_data == hold_d && dn.o_last == hold_l)) n_unstable++;
            hold_v = dn.o_valid && !dn.i_ready;
            hold_d = dn.o_data;
            hold_l = dn.o_last;
            if (dn.o_valid && dn.i_ready) begin
                got_d.push_back(dn.o_data);
                got_l.push_back(dn.o_last);
                got_c.push_back(cyc);
            end
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
                if (o_err) n_err_done++;
            end
            if (o_err) n_err++;
            if (o_busy) n_busy++;
            if (i_start) start_cyc = cyc;
        end
        prev_rden = o_rden && rstn;
    end

    int rmode = 0;
    initial begin
        dn.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       dn.i_ready = 1'b1;
                1:       dn.i_ready = ~dn.i_ready;
                2:       dn.i_ready = 1'($urandom_range(0, 1));
                default: dn.i_ready = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    task automatic clear_mon();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        n_rden = 0; n_consec = 0; n_bad_rd = 0; n_unstable = 0;
        n_done = 0; n_err = 0; n_err_done = 0; n_busy = 0;
        start_cyc = -100; done_cyc = -100;
    endtask

    logic [DW-1:0] exp_q[$];
    int            exp_left;

    // nwords < 0 keeps the FIFO contents; expectation = the first len words of the queue
    task automatic run_case(input string tag, input int nwords, input bit seq, input int len,
                            input int mode, input int thr, input bit last_on_final, input int exp_err);
        int k;
        if (nwords >= 0) begin
            fq.delete();
            for (int i = 0; i < nwords; i++)
                fq.push_back(seq ? DW'(i + 1) : {$urandom, $urandom, $urandom, $urandom});
        end
        alm_thr = thr;
        rmode   = mode;
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < len && i < fq.size(); i++) exp_q.push_back(fq[i]);
        exp_left = fq.size() - exp_q.size();
        i_start = 1'b1;
        i_len   = LW'(len);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        k = 0;
        while (n_done == 0 && k < 30 * len + 100) begin
            @(posedge clk);
            k++;
        end
        check({tag, " done_seen"}, n_done != 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check({tag, " pops"}, got_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            check($sformatf("%s data[%0d]", tag, i), got_d[i], exp_q[i]);
            check($sformatf("%s last[%0d]", tag, i), got_l[i], last_on_final && (i == exp_q.size() - 1));
        end
        check({tag, " rden_count"}, n_rden, exp_q.size());
        check({tag, " fifo_left"}, fq.size(), exp_left);
        check({tag, " done_count"}, n_done, 1);
        check({tag, " err_count"}, n_err, exp_err);
        check({tag, " err_with_done"}, n_err_done, exp_err);
        check({tag, " unstable"}, n_unstable, 0);
        check({tag, " read_empty"}, n_bad_rd, 0);
        check({tag, " busy_end"}, o_busy, 0);
    endtask

    initial begin
        int k;
        int n;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {o_busy, o_done, o_err, o_rden, dn.o_valid, dn.o_last, dn.o_data}, 0);
        rstn = 1'b1;

        run_case("t1 len4", 8, 1'b1, 4, 0, 1, 1'b1, 0);
        check("t1 first_lat", got_c.size() > 0 ? got_c[0] - start_cyc : -1, 3);
        check("t1 last_lat", got_c.size() > 3 ? got_c[3] - start_cyc : -1, 6);
        check("t1 done_lat", done_cyc - start_cyc, 7);

        run_case("t2 toggle", 10, 1'b1, 6, 1, 1, 1'b1, 0);

        run_case("t3 alm", 2, 1'b0, 2, 0, 1000, 1'b1, 0);
        check("t3 back_to_back_rden", n_consec, 0);

        alm_thr = 1;
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        i_start = 1'b1;
        i_len   = '0;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t4 done_count", n_done, 1);
        check("t4 done_lat", done_cyc - start_cyc, 1);
        check("t4 busy", n_busy, 0);
        check("t4 rden", n_rden, 0);

        fq.delete();
        for (int i = 0; i < 12; i++) fq.push_back(DW'(32'h100 + i));
        alm_thr = 1;
        rmode   = 2;
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        i_start = 1'b1;
        i_len   = LW'(6);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        k = 0;
        while (got_d.size() < 2 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t5 pops_before_reset", got_d.size() >= 2, 1);
        #1;
        rstn = 1'b0;
        #1;
        check("t5 reset outputs", {o_busy, o_done, o_err, o_rden, dn.o_valid, dn.o_last, dn.o_data}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        run_case("t5 after_reset", -1, 1'b0, 4, 0, 1, 1'b1, 0);

        run_case("t6 maxlen", 255, 1'b0, 255, 2, 1, 1'b1, 0);

        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 24);
            run_case($sformatf("t7 rnd%0d", it), n, 1'b0, $urandom_range(1, n),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 0);
        end

`ifdef FIFO_RD_TIMEOUT_EN
        run_case("t8 timeout", 3, 1'b1, 5, 0, 1, 1'b0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
